// File: rtl/grid_lane_array_if.sv
// Command/readback bus of grid_lane_array: byte-wide command port in, readback stream and checksum out.
interface grid_lane_array_if #(
   parameter int unsigned LANES = 16
);
   localparam int unsigned LW = $clog2(LANES);

   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [LW-1:0] cmd_lane;
   logic [7:0]    cmd_arg;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic          rd_last;
   logic [7:0]    chk;

   modport master (
      output cmd_valid, cmd_op, cmd_lane, cmd_arg,
      input  cmd_ready, rd_valid, rd_data, rd_last, chk
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_lane, cmd_arg,
      output cmd_ready, rd_valid, rd_data, rd_last, chk
   );
endinterface

// File: rtl/grid_lane_array.sv
// Array of independent register lanes (hold/add-step/rotate/LFSR), driven and read back
// through a byte-wide command port, with a registered XOR checksum of the lane low bytes.
module grid_lane_array #(
   parameter int unsigned LANES = 16,
   parameter int unsigned WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   grid_lane_array_if.slave bus
);
   localparam int unsigned LW = $clog2(LANES);
   localparam int unsigned NB = WIDTH / 8;
   localparam int unsigned CW = $clog2(NB + 1);

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_MODE = 2'd1;
   localparam logic [1:0] OP_READ = 2'd2;
   localparam logic [1:0] OP_RUN  = 2'd3;

   localparam logic [1:0] M_INC  = 2'd1;
   localparam logic [1:0] M_ROT  = 2'd2;
   localparam logic [1:0] M_LFSR = 2'd3;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_READ = 1'b1;

   function automatic logic [7:0] reset_chk();
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < int'(LANES); k++) r = r ^ 8'(k);
      return r;
   endfunction

   localparam logic [7:0] CHK_RST = reset_chk();

   function automatic logic [WIDTH-1:0] lane_update(input logic [WIDTH-1:0] v,
                                                    input logic [1:0] m,
                                                    input logic [5:0] s);
      case (m)
         M_INC:   return v + WIDTH'(s);
         M_ROT:   return {v[WIDTH-2:0], v[WIDTH-1]};
         M_LFSR:  return {v[WIDTH-2:0], v[WIDTH-1] ^ v[0]};
         default: return v;
      endcase
   endfunction

   logic [WIDTH-1:0] lane_q [LANES];
   logic [1:0]       mode_q [LANES];
   logic [5:0]       step_q [LANES];
   logic             run_q;

   logic [0:0]       state_q, state_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic [WIDTH-1:0] snap_q, snap_nx;
   logic             rd_valid_q, rd_valid_nx;
   logic [7:0]       rd_data_q, rd_data_nx;
   logic             rd_last_q, rd_last_nx;
   logic             ready_q, ready_nx;
   logic [7:0]       chk_q;

   logic             accept_c;
   logic             lane_hit_c;
   logic [WIDTH-1:0] sel_val_c;
   logic [7:0]       chk_c;

   assign accept_c   = bus.cmd_valid && ready_q;
   assign lane_hit_c = 32'(bus.cmd_lane) < 32'(LANES);
   assign sel_val_c  = lane_hit_c ? lane_q[bus.cmd_lane] : '0;

   assign bus.cmd_ready = ready_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_last   = rd_last_q;
   assign bus.chk       = chk_q;

   // Lane, mode and run state; a LOAD pre-empts that lane's mode update for the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(LANES); k++) begin
            lane_q[k] <= WIDTH'(k);
            mode_q[k] <= 2'd0;
            step_q[k] <= 6'd0;
         end
         run_q <= 1'b0;
      end else begin
         for (int k = 0; k < int'(LANES); k++) begin
            if (accept_c && bus.cmd_op == OP_LOAD && bus.cmd_lane == LW'(k))
               lane_q[k] <= {lane_q[k][WIDTH-9:0], bus.cmd_arg};
            else if (run_q)
               lane_q[k] <= lane_update(lane_q[k], mode_q[k], step_q[k]);
            if (accept_c && bus.cmd_op == OP_MODE && bus.cmd_lane == LW'(k)) begin
               mode_q[k] <= bus.cmd_arg[1:0];
               step_q[k] <= bus.cmd_arg[7:2];
            end
         end
         if (accept_c && bus.cmd_op == OP_RUN)
            run_q <= bus.cmd_arg[0];
      end
   end

   always_comb begin
      chk_c = 8'h00;
      for (int k = 0; k < int'(LANES); k++) chk_c = chk_c ^ lane_q[k][7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) chk_q <= CHK_RST;
      else        chk_q <= chk_c;
   end

   // Readback FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         snap_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_last_q  <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_nx;
         cnt_q      <= cnt_nx;
         snap_q     <= snap_nx;
         rd_valid_q <= rd_valid_nx;
         rd_data_q  <= rd_data_nx;
         rd_last_q  <= rd_last_nx;
         ready_q    <= ready_nx;
      end
   end

   // Next state: snapshot is taken at accept, then shifted out MSB byte first.
   always_comb begin
      state_nx    = state_q;
      cnt_nx      = cnt_q;
      snap_nx     = snap_q;
      rd_valid_nx = 1'b0;
      rd_data_nx  = 8'h00;
      rd_last_nx  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_c && bus.cmd_op == OP_READ && lane_hit_c) begin
               state_nx    = S_READ;
               snap_nx     = {sel_val_c[WIDTH-9:0], 8'h00};
               rd_valid_nx = 1'b1;
               rd_data_nx  = sel_val_c[WIDTH-1 -: 8];
               cnt_nx      = CW'(1);
            end
         end
         S_READ: begin
            if (cnt_q == CW'(NB)) begin
               state_nx = S_IDLE;
            end else begin
               rd_valid_nx = 1'b1;
               rd_data_nx  = snap_q[WIDTH-1 -: 8];
               rd_last_nx  = (cnt_q == CW'(NB - 1));
               snap_nx     = {snap_q[WIDTH-9:0], 8'h00};
               cnt_nx      = cnt_q + CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
      ready_nx = (state_nx == S_IDLE);
   end
endmodule

// File: tb/tb_grid_lane_array.sv
// Self-checking bench for grid_lane_array: directed vector table, hand sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_grid_lane_array;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   grid_lane_array_if #(.LANES(16)) b16 ();
   grid_lane_array_if #(.LANES(12)) b12 ();

   grid_lane_array #(.LANES(16), .WIDTH(32)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   grid_lane_array #(.LANES(12), .WIDTH(32)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

   // Behavioural model of the 16-lane instance.
   logic [31:0] m_lane [16];
   logic [1:0]  m_mode [16];
   logic [5:0]  m_step [16];
   bit          m_run;
   logic [7:0]  m_q [$];
   bit          m_valid, m_last, m_ready;
   logic [7:0]  m_data, m_chk;

   typedef struct {
      bit         v;
      logic [1:0] op;
      logic [3:0] ln;
      logic [7:0] arg;
      bit         rdy;
      bit         vld;
      logic [7:0] data;
      bit         last;
      logic [7:0] chk;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(bit v, logic [1:0] op, logic [3:0] ln, logic [7:0] arg,
                               bit rdy, bit vld, logic [7:0] d, bit last, logic [7:0] c);
      vec_t r;
      r.v = v; r.op = op; r.ln = ln; r.arg = arg;
      r.rdy = rdy; r.vld = vld; r.data = d; r.last = last; r.chk = c;
      return r;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < 16; k++) begin
         m_lane[k] = 32'(k);
         m_mode[k] = 2'd0;
         m_step[k] = 6'd0;
         c = c ^ 8'(k);
      end
      m_run = 1'b0;
      m_q.delete();
      m_valid = 1'b0; m_last = 1'b0; m_data = 8'h00; m_ready = 1'b1;
      m_chk = c;
   endfunction

   function automatic void model_step(bit v, logic [1:0] op, logic [3:0] ln, logic [7:0] arg);
      logic [31:0] nl [16];
      logic [31:0] x;
      logic [7:0]  c;
      bit          acc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc = v && m_ready;
      c = 8'h00;
      for (int k = 0; k < 16; k++) begin
         x = m_lane[k];
         c = c ^ x[7:0];
         nl[k] = x;
         if (m_run) begin
            case (m_mode[k])
               2'd1: nl[k] = x + {26'd0, m_step[k]};
               2'd2: nl[k] = (x << 1) | (x >> 31);
               2'd3: nl[k] = (x << 1) | ((x >> 31) ^ (x & 32'd1));
               default: nl[k] = x;
            endcase
         end
      end
      if (acc) begin
         case (op)
            2'd0: nl[ln] = (m_lane[ln] << 8) | {24'd0, arg};
            2'd1: begin m_mode[ln] = arg[1:0]; m_step[ln] = arg[7:2]; end
            2'd2: for (int b = 3; b >= 0; b--) m_q.push_back(8'(m_lane[ln] >> (8 * b)));
            default: m_run = arg[0];
         endcase
      end
      for (int k = 0; k < 16; k++) m_lane[k] = nl[k];
      m_chk = c;
      if (m_q.size() > 0) begin
         m_data  = m_q.pop_front();
         m_valid = 1'b1;
         m_last  = (m_q.size() == 0);
      end else begin
         m_data = 8'h00; m_valid = 1'b0; m_last = 1'b0;
      end
      m_ready = !m_valid;
   endfunction

   task automatic cycle(input bit v, input logic [1:0] op, input logic [3:0] ln, input logic [7:0] arg);
      b16.cmd_valid = v;
      b16.cmd_op    = op;
      b16.cmd_lane  = ln;
      b16.cmd_arg   = arg;
      @(posedge clk);
      model_step(v, op, ln, arg);
      #1;
      check("model", 32'({b16.cmd_ready, b16.rd_valid, b16.rd_last, b16.rd_data, b16.chk}),
            32'({m_ready, m_valid, m_last, m_data, m_chk}));
   endtask

   task automatic idle();
      cycle(1'b0, 2'd0, 4'd0, 8'h00);
   endtask

   task automatic load_word(input logic [3:0] ln, input logic [31:0] w);
      for (int b = 3; b >= 0; b--) cycle(1'b1, 2'd0, ln, 8'(w >> (8 * b)));
   endtask

   // Issues a READ and collects the bytes; returns once cmd_ready is back.
   task automatic read_lane(input logic [3:0] ln, output logic [31:0] val);
      int n;
      val = 32'd0;
      n = 0;
      cycle(1'b1, 2'd2, ln, 8'h00);
      for (int i = 0; i < 4; i++) begin
         if (b16.rd_valid) begin
            val = {val[23:0], b16.rd_data};
            n++;
         end
         idle();
      end
      check("read_bytes", 32'(n), 32'd4);
   endtask

   initial begin
      logic [31:0] val;
      b12.cmd_valid = 1'b0; b12.cmd_op = 2'd0; b12.cmd_lane = 4'd0; b12.cmd_arg = 8'h00;
      model_reset();

      rst_n = 1'b0;
      idle();
      idle();
      rst_n = 1'b1;
      check("rst_out", 32'({b16.cmd_ready, b16.rd_valid, b16.rd_last, b16.rd_data, b16.chk}),
            32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
      check("rst_chk12", 32'({b12.cmd_ready, b12.chk}), 32'({1'b1, 8'h00}));

      tbl[0]  = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      tbl[1]  = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      tbl[2]  = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      tbl[3]  = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 8'h00);
      tbl[4]  = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      tbl[5]  = mk(1'b1, 2'd0, 4'd3, 8'hDE, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      tbl[6]  = mk(1'b1, 2'd0, 4'd3, 8'hAD, 1'b1, 1'b0, 8'h00, 1'b0, 8'hDD);
      tbl[7]  = mk(1'b1, 2'd0, 4'd3, 8'hBE, 1'b1, 1'b0, 8'h00, 1'b0, 8'hAE);
      tbl[8]  = mk(1'b1, 2'd0, 4'd3, 8'hEF, 1'b1, 1'b0, 8'h00, 1'b0, 8'hBD);
      tbl[9]  = mk(1'b1, 2'd2, 4'd3, 8'h00, 1'b0, 1'b1, 8'hDE, 1'b0, 8'hEC);
      tbl[10] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'hAD, 1'b0, 8'hEC);
      tbl[11] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'hBE, 1'b0, 8'hEC);
      tbl[12] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'hEF, 1'b1, 8'hEC);
      tbl[13] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'hEC);
      tbl[14] = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hEC);
      tbl[15] = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hEC);
      tbl[16] = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hEC);
      tbl[17] = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 8'hEC);
      tbl[18] = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'hEC);
      tbl[19] = mk(1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hEC);
      tbl[20] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hEC);
      tbl[21] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hEC);
      tbl[22] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 8'hEC);
      tbl[23] = mk(1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'hEC);

      for (int i = 0; i < 24; i++) begin
         cycle(tbl[i].v, tbl[i].op, tbl[i].ln, tbl[i].arg);
         check($sformatf("vec%0d", i),
               32'({b16.cmd_ready, b16.rd_valid, b16.rd_last, b16.rd_data, b16.chk}),
               32'({tbl[i].rdy, tbl[i].vld, tbl[i].last, tbl[i].data, tbl[i].chk}));
      end

      // INC step 3 for 10 edges, then wrap from all-ones with step 1.
      cycle(1'b1, 2'd1, 4'd2, 8'h0D);
      cycle(1'b1, 2'd3, 4'd0, 8'h01);
      for (int i = 0; i < 10; i++) idle();
      read_lane(4'd2, val);
      check("inc_lane2", val, 32'h0000_0020);
      cycle(1'b1, 2'd3, 4'd0, 8'h00);
      cycle(1'b1, 2'd1, 4'd2, 8'h05);
      load_word(4'd2, 32'hFFFF_FFFF);
      cycle(1'b1, 2'd3, 4'd0, 8'h01);
      cycle(1'b1, 2'd3, 4'd0, 8'h00);
      read_lane(4'd2, val);
      check("inc_wrap", val, 32'h0000_0000);

      // ROT and LFSR single updates.
      cycle(1'b1, 2'd1, 4'd4, 8'h02);
      cycle(1'b1, 2'd1, 4'd6, 8'h03);
      cycle(1'b1, 2'd1, 4'd8, 8'h03);
      load_word(4'd4, 32'h8000_0001);
      load_word(4'd6, 32'h0000_0001);
      load_word(4'd8, 32'h8000_0000);
      cycle(1'b1, 2'd3, 4'd0, 8'h01);
      cycle(1'b1, 2'd3, 4'd0, 8'h00);
      read_lane(4'd4, val);
      check("rot", val, 32'h0000_0003);
      read_lane(4'd6, val);
      check("lfsr_lo", val, 32'h0000_0003);
      read_lane(4'd8, val);
      check("lfsr_hi", val, 32'h0000_0001);

      // Snapshot while counting; lane keeps counting through the readback.
      cycle(1'b1, 2'd1, 4'd7, 8'h05);
      load_word(4'd7, 32'h0000_0100);
      cycle(1'b1, 2'd3, 4'd0, 8'h01);
      idle(); idle(); idle();
      read_lane(4'd7, val);
      check("snap_lane7", val, 32'h0000_0103);
      cycle(1'b1, 2'd3, 4'd0, 8'h00);
      read_lane(4'd7, val);
      check("count_lane7", val, 32'h0000_0109);

      // Reset during byte 2 of a readback.
      cycle(1'b1, 2'd3, 4'd0, 8'h01);
      cycle(1'b1, 2'd2, 4'd5, 8'h00);
      idle();
      idle();
      check("mid_byte2", 32'({b16.rd_valid, b16.rd_data}), 32'({1'b1, 8'h00}));
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      check("abort", 32'({b16.rd_valid, b16.rd_last, b16.cmd_ready}), 32'({1'b0, 1'b0, 1'b1}));
      idle(); idle();
      read_lane(4'd7, val);
      check("rst_lane7", val, 32'h0000_0007);
      read_lane(4'd5, val);
      check("rst_lane5", val, 32'h0000_0005);

      // Out-of-range lane on the 12-lane instance: no bytes, no busy period.
      b12.cmd_valid = 1'b1; b12.cmd_op = 2'd2; b12.cmd_lane = 4'd15;
      idle();
      b12.cmd_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("oob12", 32'({b12.rd_valid, b12.cmd_ready}), 32'({1'b0, 1'b1}));
         idle();
      end

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         cycle($urandom_range(0, 9) < 7, 2'($urandom), 4'($urandom), 8'($urandom));
      end
      rst_n = 1'b1;
      cycle(1'b1, 2'd3, 4'd0, 8'h00);
      for (int k = 0; k < 16; k++) begin
         idle(); idle(); idle(); idle();
         read_lane(4'(k), val);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/grid_lane_array.md
# grid_lane_array

Parametrised array of LANES independent WIDTH-bit register lanes, each with its own update mode: hold, add-step, rotate, or LFSR. Lanes are loaded, configured and read back through a single byte-wide command port. It is the configurable successor to the fixed striped register fields in the tile top level. A registered XOR checksum gives a cheap always-on observable on the tile pins.

## Interface
- LANES, 16, number of lanes; >= 2.
- WIDTH, 32, lane width in bits; multiple of 8, >= 16.
- LW, $clog2(LANES), lane-select width (derived).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0 LOAD, 1 MODE, 2 READ, 3 RUN.
- cmd_lane  in  LW  target lane (ignored by RUN).
- cmd_arg  in  8  command argument.
- rd_valid  out  1  rd_data holds a readback byte.
- rd_data  out  8  readback byte, MSB-first.
- rd_last  out  1  final byte of a readback.
- chk  out  8  registered XOR of lane[k][7:0] over all lanes.

## Operation
- Per-lane state: lane[WIDTH], mode[2], step[6]. Global state: run[1], busy FSM (IDLE/READ), byte counter, snapshot shift register.
- Reset values:
  - lane[k] = k, zero-extended; mode = 0 (HOLD); step = 0; run = 0.
  - FSM = IDLE; cmd_ready = 1; rd_valid = 0; rd_data = 0; rd_last = 0.
  - chk = XOR of reset lane low bytes (LANES=16 → 0x00).
- LOAD: lane <= {lane[WIDTH-9:0], cmd_arg}, shifting the byte in at the LSB. For that edge, the load replaces the lane's mode update.
- MODE: mode <= cmd_arg[1:0], step <= cmd_arg[7:2]. Takes effect from the next edge.
- RUN: run <= cmd_arg[0]. Takes effect from the next edge.
- READ: snapshot = lane value before this edge's update. FSM goes to READ and emits WIDTH/8 bytes.
- Update on each edge with run=1, per lane not being loaded:
  - HOLD (0): unchanged.
  - INC (1): lane + step, zero-extended, wraps mod 2^WIDTH.
  - ROT (2): {lane[WIDTH-2:0], lane[WIDTH-1]}.
  - LFSR (3): {lane[WIDTH-2:0], lane[WIDTH-1]^lane[0]}.
- Updates continue during READ. LOAD/MODE/RUN are not accepted during READ because cmd_ready=0.
- cmd_lane >= LANES: command accepted, no effect. READ to such a lane produces no bytes and no busy period.
- chk updates every edge from current lane values.
- Reset asserted mid-READ aborts the readback; all state returns to reset values on that edge.

## Timing
- Command accepted at edge A.
- LOAD/MODE/RUN: effect visible in the cycle after A. cmd_ready stays 1.
- READ:
  - rd_valid=1 in cycles A+1 .. A+WIDTH/8. Byte k (0 = MSB) appears in cycle A+1+k.
  - rd_last=1 only in cycle A+WIDTH/8.
  - cmd_ready=0 in cycles A+1 .. A+WIDTH/8; it returns to 1 in cycle A+1+WIDTH/8.
  - Back-to-back READs are therefore separated by WIDTH/8 busy cycles.
- rd_data returns to 0 when rd_valid=0.
- chk latency: 1 cycle after a lane change.
- No combinational path from cmd_* to any output. cmd_ready depends only on FSM state.

## Test plan
(LANES=16, WIDTH=32 throughout.)
- Reset, then READ lane 5 → rd_data 00,00,00,05 on 4 consecutive cycles; rd_last on the 4th; cmd_ready low for exactly those 4 cycles; chk=0x00.
- With run=0, LOAD lane 3 with DE,AD,BE,EF, then READ lane 3 → bytes DE,AD,BE,EF; chk=0x03^0xEF=0xEC.
- MODE lane 2 arg 0x0D (INC, step 3), then RUN 1, then 10 update edges → lane 2 = 0x20. Then LOAD 0xFFFFFFFF into lane 2 with step 1 → lane 2 = 0x00000000 after 1 update.
- ROT on lane 0x80000001 → 0x00000003 after 1 update. LFSR on 0x00000001 → 0x00000003; on 0x80000000 → 0x00000001.
- READ lane 7 while lane 7 is INC step 1 and running → snapshot equals the pre-accept value; the lane keeps counting during the readback; a cmd_valid held during busy is accepted only in cycle A+5.
- rst_n low during byte 2 of a READ → next cycle rd_valid=0, rd_last=0, cmd_ready=1, run=0, lane k = k; a cmd_lane=15 READ issued after reset on LANES=12 produces no bytes.
